// File: rtl/linear_network_multicast_bp.sv
// Registered multicast distribution chain with per-node valid/ready backpressure and a global stall.
// Optional stall/packet counters are built when LINEAR_NETWORK_PERF_CNT_EN is defined.
module linear_network_multicast_bp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_dest,
  output logic                           o_in_ready,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus,
  input  logic [NUM_NODE-1:0]            i_ready,
  output logic [31:0]                    o_stall_cnt,
  output logic [31:0]                    o_pkt_cnt
);

  logic [NUM_NODE-1:0]   vld;
  logic [DATA_WIDTH-1:0] data     [NUM_NODE];
  logic [NUM_NODE-1:0]   mask     [NUM_NODE];
  logic [NUM_NODE-1:0]   clr_mask [NUM_NODE];
  logic [NUM_NODE-1:0]   tgt;
  logic [NUM_NODE-1:0]   fwd;
  logic [NUM_NODE-1:0]   hs;
  logic                  stall;
  logic                  shift;
  logic                  accept;

  function automatic logic [NUM_NODE-1:0] above_mask(input int s);
    logic [NUM_NODE-1:0] m;
    for (int k = 0; k < NUM_NODE; k++) m[k] = (k > s);
    return m;
  endfunction

  // A stage only forwards when a destination remains strictly downstream of it.
  always_comb begin
    tgt        = '0;
    fwd        = '0;
    o_data_bus = '0;
    for (int s = 0; s < NUM_NODE; s++) begin
      tgt[s]      = vld[s] & mask[s][s];
      fwd[s]      = vld[s] & (|(mask[s] & above_mask(s)));
      clr_mask[s] = mask[s];
      clr_mask[s][s] = 1'b0;
      if (o_valid[s]) o_data_bus[s*DATA_WIDTH +: DATA_WIDTH] = data[s];
    end
  end

  assign o_valid    = {NUM_NODE{i_en}} & tgt;
  assign hs         = o_valid & i_ready;
  assign stall      = |(tgt & ~i_ready);
  assign shift      = i_en & ~stall;
  assign o_in_ready = shift & ~rst;
  assign accept     = i_valid & o_in_ready;

  // Chain stage registers: shift when unstalled, otherwise retire delivered bits in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < NUM_NODE; s++) begin
        data[s] <= '0;
        mask[s] <= '0;
      end
    end else if (shift) begin
      vld[0]  <= accept;
      data[0] <= accept ? i_data_bus : '0;
      mask[0] <= accept ? i_dest : '0;
      for (int s = 0; s < NUM_NODE-1; s++) begin
        vld[s+1]  <= fwd[s];
        data[s+1] <= fwd[s] ? data[s] : '0;
        mask[s+1] <= fwd[s] ? clr_mask[s] : '0;
      end
    end else if (i_en) begin
      for (int s = 0; s < NUM_NODE; s++)
        if (hs[s]) mask[s][s] <= 1'b0;
    end
  end

`ifdef LINEAR_NETWORK_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] pkt_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      pkt_cnt   <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, i_en & stall);
      pkt_cnt   <= sat_inc(pkt_cnt, accept);
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_pkt_cnt   = pkt_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_pkt_cnt   = '0;
`endif

endmodule

// File: tb/tb_linear_network_multicast_bp.sv
// Randomized and directed bench for linear_network_multicast_bp against a packet-list reference model.
module tb_linear_network_multicast_bp;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic [N-1:0]  i_dest;
  logic          o_in_ready;
  logic [N-1:0]  o_valid;
  logic [DW*N-1:0] o_data_bus;
  logic [N-1:0]  i_ready;
  logic [31:0]   o_stall_cnt;
  logic [31:0]   o_pkt_cnt;

  linear_network_multicast_bp #(.DATA_WIDTH(DW), .NUM_NODE(N)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_dest(i_dest), .o_in_ready(o_in_ready), .o_valid(o_valid), .o_data_bus(o_data_bus),
    .i_ready(i_ready), .o_stall_cnt(o_stall_cnt), .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clk = ~clk;

  // Each in-flight packet: the node it currently sits at and the destinations still owed.
  typedef struct {
    int           pos;
    logic [N-1:0] dest;
    logic [DW-1:0] d;
  } pkt_t;

  pkt_t q[$];
  int   m_pkt, m_stall;
  logic m_st;
  int   total, passed;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_pkt();
`ifdef LINEAR_NETWORK_PERF_CNT_EN
    return m_pkt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef LINEAR_NETWORK_PERF_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cycle_begin(input logic en, input logic v, input logic [DW-1:0] d,
                             input logic [N-1:0] dst, input logic [N-1:0] rdy);
    logic [N-1:0]    ev;
    logic [DW*N-1:0] eb;
    logic            st;
    @(negedge clk);
    i_en = en; i_valid = v; i_data_bus = d; i_dest = dst; i_ready = rdy;
    #1;
    ev = '0; eb = '0; st = 1'b0;
    foreach (q[i]) begin
      if (q[i].dest[q[i].pos]) begin
        if (!rdy[q[i].pos]) st = 1'b1;
        if (en) begin
          ev[q[i].pos] = 1'b1;
          eb[q[i].pos*DW +: DW] = q[i].d;
        end
      end
    end
    m_st = st;
    chk("o_valid", o_valid, ev);
    chk("o_data_bus", o_data_bus, eb);
    chk("o_in_ready", o_in_ready, en & ~st);
    chk("o_pkt_cnt", o_pkt_cnt, exp_pkt());
    chk("o_stall_cnt", o_stall_cnt, exp_stall());
  endtask

  task automatic cycle_end();
    pkt_t tmp[$];
    pkt_t e;
    @(posedge clk);
    if (i_en) begin
      foreach (q[i]) begin
        e = q[i];
        if (e.dest[e.pos] && i_ready[e.pos]) e.dest[e.pos] = 1'b0;
        q[i] = e;
      end
      if (m_st) m_stall++;
      else begin
        tmp = {};
        foreach (q[i]) begin
          e = q[i];
          e.pos++;
          if (e.pos < N && e.dest != '0) tmp.push_back(e);
        end
        q = tmp;
        if (i_valid) begin
          q.push_back('{pos: 0, dest: i_dest, d: i_data_bus});
          m_pkt++;
        end
      end
    end
  endtask

  task automatic cyc(input logic en, input logic v, input logic [DW-1:0] d,
                     input logic [N-1:0] dst, input logic [N-1:0] rdy);
    cycle_begin(en, v, d, dst, rdy);
    cycle_end();
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q = {}; m_pkt = 0; m_stall = 0;
  endtask

  logic [N-1:0] mc_exp [5];
  logic [DW*N-1:0] uni_bus;

  initial begin
    total = 0; passed = 0; m_pkt = 0; m_stall = 0; m_st = 1'b0;
    rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_dest = '0; i_ready = '1;
    #3;
    chk("reset o_valid", o_valid, 0);
    chk("reset o_data_bus", o_data_bus, 0);
    chk("reset o_in_ready", o_in_ready, 0);
    chk("reset o_pkt_cnt", o_pkt_cnt, 0);
    chk("reset o_stall_cnt", o_stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Unicast to node 2
    uni_bus = '0;
    uni_bus[2*DW +: DW] = 32'hA5A5_0001;
    cyc(1, 1, 32'hA5A5_0001, 4'b0100, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      cycle_begin(1, 0, '0, '0, 4'hF);
      chk("unicast o_valid", o_valid, (k == 3) ? 4'b0100 : 4'b0000);
      chk("unicast o_data_bus", o_data_bus, (k == 3) ? uni_bus : '0);
      cycle_end();
    end

    // Multicast 1011
    mc_exp[0] = 4'b0001; mc_exp[1] = 4'b0010; mc_exp[2] = 4'b0000;
    mc_exp[3] = 4'b1000; mc_exp[4] = 4'b0000;
    cyc(1, 1, 32'h0000_00FF, 4'b1011, 4'hF);
    for (int k = 0; k < 5; k++) begin
      cycle_begin(1, 0, '0, '0, 4'hF);
      chk("multicast o_valid", o_valid, mc_exp[k]);
      cycle_end();
    end

    // Back-to-back broadcast
    for (int k = 0; k < 4; k++) cyc(1, 1, 32'hB0 + k, 4'b1111, 4'hF);
    cycle_begin(1, 0, '0, '0, 4'hF);
    chk("broadcast o_valid", o_valid, 4'b1111);
    chk("broadcast node0", o_data_bus[0 +: DW], 32'hB3);
    chk("broadcast node3", o_data_bus[3*DW +: DW], 32'hB0);
    cycle_end();
    for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0, 4'hF);

    // Backpressure on node 1
    cyc(1, 1, 32'h0000_BEEF, 4'b0011, 4'hF);
    cycle_begin(1, 0, '0, '0, 4'hF);
    chk("bp node0 o_valid", o_valid, 4'b0001);
    cycle_end();
    for (int k = 0; k < 3; k++) begin
      cycle_begin(1, 1, 32'h77, 4'b0100, 4'b1101);
      chk("bp stall o_valid", o_valid, 4'b0010);
      chk("bp stall o_in_ready", o_in_ready, 1'b0);
      cycle_end();
    end
    cycle_begin(1, 1, 32'h77, 4'b0100, 4'hF);
    chk("bp release o_valid", o_valid, 4'b0010);
    chk("bp release o_in_ready", o_in_ready, 1'b1);
    cycle_end();
    for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0, 4'hF);

    // Zero mask
    cyc(1, 1, 32'h55, 4'b0000, 4'hF);
    for (int k = 0; k < 4; k++) begin
      cycle_begin(1, 0, '0, '0, 4'hF);
      chk("zero mask o_valid", o_valid, 4'b0000);
      cycle_end();
    end

    // Enable dropped mid-flight
    cyc(1, 1, 32'h1234, 4'b1000, 4'hF);
    cyc(1, 0, '0, '0, 4'hF);
    cyc(1, 0, '0, '0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      cycle_begin(0, 1, 32'h9, 4'b0001, 4'hF);
      chk("en low o_valid", o_valid, 4'b0000);
      chk("en low o_in_ready", o_in_ready, 1'b0);
      cycle_end();
    end
    cyc(1, 0, '0, '0, 4'hF);
    cycle_begin(1, 0, '0, '0, 4'hF);
    chk("en resume o_valid", o_valid, 4'b1000);
    chk("en resume data", o_data_bus[3*DW +: DW], 32'h1234);
    cycle_end();

    // Counters: 5 packets, 2 stall cycles
    sync_reset();
    for (int k = 0; k < 4; k++) cyc(1, 1, 32'hC0 + k, 4'b0001, 4'hF);
    cyc(1, 1, 32'hC4, 4'b0010, 4'hF);
    cyc(1, 0, '0, '0, 4'hF);
    cyc(1, 0, '0, '0, 4'b1101);
    cyc(1, 0, '0, '0, 4'b1101);
    cyc(1, 0, '0, '0, 4'hF);
    cycle_begin(1, 0, '0, '0, 4'hF);
`ifdef LINEAR_NETWORK_PERF_CNT_EN
    chk("perf pkt literal", o_pkt_cnt, 32'd5);
    chk("perf stall literal", o_stall_cnt, 32'd2);
`else
    chk("perf pkt literal", o_pkt_cnt, 32'd0);
    chk("perf stall literal", o_stall_cnt, 32'd0);
`endif
    cycle_end();

    // Asynchronous reset with three packets in flight
    for (int k = 0; k < 3; k++) cyc(1, 1, 32'hD0 + k, 4'b1000, 4'hF);
    cycle_begin(1, 0, '0, '0, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst o_valid", o_valid, 4'b0000);
    chk("async rst o_in_ready", o_in_ready, 1'b0);
    chk("async rst pkt_cnt", o_pkt_cnt, 0);
    chk("async rst stall_cnt", o_stall_cnt, 0);
    q = {}; m_pkt = 0; m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) cyc(1, 0, '0, '0, 4'hF);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), $urandom,
          N'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end
    for (int k = 0; k < 8; k++) cyc(1, 0, '0, '0, 4'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/linear_network_multicast_bp.md
Name: linear_network_multicast_bp

Overview:
- Parametrised successor to the fixed 4-node unicast linear chain. One source drives a registered chain of NUM_NODE stages; each packet carries a NUM_NODE-bit destination mask, so any subset of nodes can be targeted (unicast, multicast or broadcast).
- Adds per-node valid/ready backpressure with a global chain stall.
- Clears a node's mask bit once that node accepts the packet, and retires a packet early once no destinations remain downstream.
- Sits between the distribution buffer and the PE column.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- NUM_NODE, 4, number of nodes/stages (>=2, any integer, not restricted to a power of 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_en  input  1  global enable; low freezes the chain.
- i_valid  input  1  source packet valid.
- i_data_bus  input  DATA_WIDTH  source payload.
- i_dest  input  NUM_NODE  destination mask; bit k targets node k.
- o_in_ready  output  1  chain accepts a source packet this cycle.
- o_valid  output  NUM_NODE  per-node delivery valid.
- o_data_bus  output  DATA_WIDTH*NUM_NODE  node k payload at [k*DATA_WIDTH+:DATA_WIDTH].
- i_ready  input  NUM_NODE  per-node consumer ready.
- o_stall_cnt  output  32  stall-cycle counter (see Optional Feature).
- o_pkt_cnt  output  32  accepted-packet counter (see Optional Feature).

Behaviour:
- State: each stage s in 0..NUM_NODE-1 holds a register triple {vld[s], data[s], mask[s]}.
- Reset (asynchronous, rst=1): all vld, data and mask cleared; counters cleared. All outputs are 0 except o_in_ready, which is 0 while rst=1.
- Reset mid-operation discards all in-flight packets with no partial delivery afterwards.
- Node output:
  - o_valid[s] = i_en & vld[s] & mask[s][s].
  - Node s data slot = data[s] when o_valid[s] is high, else all zeros.
- Delivery: handshake at node s when o_valid[s] & i_ready[s].
- Stall: stall = OR over s of (vld[s] & mask[s][s] & ~i_ready[s]).
- Handshakes during a stall:
  - The chain does not shift.
  - Any stage whose node handshakes clears its own bit mask[s][s] on that edge, so no duplicate delivery.
  - Other stages hold their contents.
- Input: o_in_ready = i_en & ~stall & ~rst. A packet is accepted when i_valid & o_in_ready.
- Shift (i_en & ~stall), all stages simultaneously:
  - Stage 0 loads the accepted packet. If no packet is accepted, stage 0 loads a bubble (vld=0, data=0, mask=0).
  - Stage s+1 loads stage s with bit s of the mask cleared.
  - Early retire: if mask[s] bits s+1..NUM_NODE-1 are all zero, stage s+1 loads a bubble instead; data is zeroed so it does not toggle downstream.
  - Last stage contents are discarded after the shift.
- Zero mask: a packet with i_dest=0 is accepted, counted, and retired at stage 0 (never delivered). Same rule for bits at or above NUM_NODE, which do not exist.
- Latency: a packet accepted at edge t presents o_valid[k] in the cycle after edge t+k (k+1 cycles), plus any stall cycles.
- Ordering: in-order per node. Throughput: 1 packet/cycle with no stalls.
- i_en=0:
  - All state is held.
  - o_valid and o_in_ready are 0, and no handshakes occur.
  - Counters hold.
- Simultaneous events:
  - A stalled node and a handshaking node in the same cycle: the handshake bit clears and the chain stays stalled.
  - Stall release and a new i_valid in the same cycle: the packet is accepted on that edge.

Optional Feature:
- Macro LINEAR_NETWORK_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments every cycle with i_en & stall.
  - o_pkt_cnt increments on every accepted packet.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF (no wrap).
  - Both are cleared by rst.
- Undefined: the counters are not instantiated, and both ports are tied to 0.

Test Plan (DATA_WIDTH=32, NUM_NODE=4):
- Unicast: i_dest=4'b0100, data=32'hA5A5_0001, all i_ready=1 -> o_valid=4'b0100 exactly 3 cycles after acceptance, slot 2=32'hA5A5_0001, other slots 0, packet retired after stage 2.
- Multicast/broadcast: i_dest=4'b1011, data=32'h0000_00FF -> node0 at +1, node1 at +2, node3 at +4 cycles; node2 never valid. Back-to-back 4'b1111 packets give 1 pkt/cycle per node, in order.
- Backpressure:
  - Setup: i_dest=4'b0011, i_ready[1]=0 for 3 cycles.
  - Node0 delivers once; node1 holds o_valid=1 for 3 cycles.
  - o_in_ready=0 during the stall.
  - No duplicate at node0; delivery completes when i_ready[1]=1.
- Zero mask and enable: i_dest=0 is accepted with no o_valid anywhere. i_en dropped for 2 cycles mid-flight -> outputs 0, contents intact, delivery resumes 2 cycles late.
- Reset mid-flight: assert rst asynchronously (between clock edges) with 3 packets in flight -> o_valid=0 immediately, no later deliveries, counters=0.
- Perf counters (macro defined): 5 packets and 2 stall cycles -> o_pkt_cnt=5, o_stall_cnt=2. Macro undefined -> both read 0.
